jt10_dac_serial: RTL

// - Downstream of the FM/ADPCM stereo accumulator: takes its 16-bit signed left/right sums once per sample.
// - Converts each channel to YM3016-style float: 10-bit mantissa plus 3-bit exponent.
// - Shifts both words out on a 3-wire serial DAC bus (bck/lrck/sdo), double-buffered against the sample rate.

---
 rtl/jt10_dac_serial.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/jt10_dac_serial.sv
// Stereo 16-bit sums -> YM3016-style float words, shifted out on a bck/lrck/sdo DAC bus.
// Optional macro JT10_DAC_ROUND_EN: round-half-up mantissa with saturation instead of truncation.
module jt10_dac_serial #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        sample,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic        busy,
  output logic        bck,
  output logic        lrck,
  output logic        sdo,
  output logic        overrun
);

  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(DIV / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] tick_r, tick_s;
  logic [4:0]    bit_r, bit_s;
  logic [31:0]   shift_r, shift_s;
  logic [15:0]   hold_left_r, hold_right_r;
  logic          hold_full_r, hold_full_s;
  logic          last_s;
  logic          busy_s, bck_s, lrck_s, sdo_s, overrun_s;

  // exp is the narrowest window whose upper bits are pure sign extension
  function automatic logic [15:0] to_float(input logic [15:0] x);
    logic [15:0] top;
    logic [2:0]  e;
    logic [9:0]  m;
`ifdef JT10_DAC_ROUND_EN
    logic        rb;
`endif
    e = 3'd7;
    for (int i = 7; i >= 1; i--) begin
      top = 16'($signed(x) >>> (i + 8));
      e = (top == 16'h0000 || top == 16'hFFFF) ? 3'(i) : e;
    end
    m = 10'(x >> (e - 3'd1));
`ifdef JT10_DAC_ROUND_EN
    rb = 1'(x >> (e - 3'd2));
    if (e >= 3'd2 && rb) begin
      m = (m == 10'h1FF) ? 10'h1FF : m + 10'd1;
    end
`endif
    return {3'b000, m, e};
  endfunction

  assign last_s = (bit_r == 5'd31) && (tick_r == TICK_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else if (clk_en) begin
      state_r <= state_s;
    end
  end

  // FSM next state; a sample on the final tick chains straight into LOAD
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = hold_full_r ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_s = ST_SHIFT;
      ST_SHIFT: begin
        if (last_s) begin
          state_s = (hold_full_r || sample) ? ST_LOAD : ST_IDLE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default:  state_s = ST_IDLE;
    endcase
  end

  // Next values of bit/tick counters, shift register and hold flag
  always_comb begin
    tick_s  = tick_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    if (state_r == ST_LOAD) begin
      tick_s  = {TW{1'b0}};
      bit_s   = 5'd0;
      shift_s = {to_float(hold_right_r), to_float(hold_left_r)};
    end else if (state_r == ST_SHIFT && tick_r == TICK_LAST) begin
      tick_s  = {TW{1'b0}};
      bit_s   = bit_r + 5'd1;
      shift_s = {1'b0, shift_r[31:1]};
    end else if (state_r == ST_SHIFT) begin
      tick_s  = tick_r + TW'(1);
    end else begin
      tick_s  = {TW{1'b0}};
      bit_s   = 5'd0;
    end
    hold_full_s = sample | (hold_full_r & (state_r != ST_LOAD));
  end

  // FSM outputs, computed from the next state so the registered pins track the counters
  always_comb begin
    busy_s    = (state_s != ST_IDLE);
    bck_s     = (state_s == ST_SHIFT) && (tick_s >= TICK_HALF);
    lrck_s    = (state_s == ST_SHIFT) && bit_s[4];
    sdo_s     = (state_s == ST_SHIFT) && shift_s[0];
    overrun_s = sample && hold_full_r && (state_r != ST_LOAD);
  end

  // Datapath, hold buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r       <= {TW{1'b0}};
      bit_r        <= 5'd0;
      shift_r      <= 32'h0000_0000;
      hold_left_r  <= 16'h0000;
      hold_right_r <= 16'h0000;
      hold_full_r  <= 1'b0;
      busy         <= 1'b0;
      bck          <= 1'b0;
      lrck         <= 1'b0;
      sdo          <= 1'b0;
      overrun      <= 1'b0;
    end else if (clk_en) begin
      tick_r      <= tick_s;
      bit_r       <= bit_s;
      shift_r     <= shift_s;
      hold_full_r <= hold_full_s;
      if (sample) begin
        hold_left_r  <= left;
        hold_right_r <= right;
      end
      busy    <= busy_s;
      bck     <= bck_s;
      lrck    <= lrck_s;
      sdo     <= sdo_s;
      overrun <= overrun_s;
    end
  end

endmodule
